// File: rtl/eq_key_if.sv
// Purpose: keyboard-command and coefficient-bank signals of the equalizer key
//          controller, bundled into one interface.
// Signals:
//   key_code/key_valid  scan code and one-cycle strobe from the break-code filter
//   band_sel            currently selected band
//   cfg_req/cfg_band/cfg_gain/cfg_ack  write handshake to the coefficient bank
//   busy/key_drop/err_timeout          controller status
// Modports: master = keyboard filter + coefficient bank side, slave = controller.
interface eq_key_if #(
  parameter int unsigned GAIN_W = 4
) ();
  logic [7:0]        key_code;
  logic              key_valid;
  logic [1:0]        band_sel;
  logic              cfg_req;
  logic [1:0]        cfg_band;
  logic [GAIN_W-1:0] cfg_gain;
  logic              cfg_ack;
  logic              busy;
  logic              key_drop;
  logic              err_timeout;

  modport master (
    output key_code, key_valid, cfg_ack,
    input  band_sel, cfg_req, cfg_band, cfg_gain, busy, key_drop, err_timeout
  );

  modport slave (
    input  key_code, key_valid, cfg_ack,
    output band_sel, cfg_req, cfg_band, cfg_gain, busy, key_drop, err_timeout
  );
endinterface

// File: rtl/eq_key_controller.sv
// Purpose: maps PS/2 set-2 key strobes to equalizer band select, gain up/down
//          and restore-defaults commands; keeps one gain register per band and
//          writes changed gains to the coefficient bank over a req/ack handshake.
// Ports:
//   clk  system clock
//   rst  asynchronous, active-high reset
//   bus  eq_key_if.slave: key_code/key_valid in, cfg_ack in,
//        band_sel/cfg_req/cfg_band/cfg_gain/busy/key_drop/err_timeout out
module eq_key_controller #(
  parameter int unsigned NUM_BANDS    = 3,
  parameter int unsigned GAIN_W       = 4,
  parameter int unsigned GAIN_MAX     = 15,
  parameter int unsigned GAIN_DEFAULT = 8,
  parameter int unsigned ACK_TIMEOUT  = 255
) (
  input  logic    clk,
  input  logic    rst,
  eq_key_if.slave bus
);

  localparam int unsigned CNT_W     = 8;
  localparam int unsigned MAX_BANDS = 4;

  localparam logic [7:0] KEY_BAND0   = 8'h16;
  localparam logic [7:0] KEY_BAND1   = 8'h1E;
  localparam logic [7:0] KEY_BAND2   = 8'h26;
  localparam logic [7:0] KEY_BAND3   = 8'h25;
  localparam logic [7:0] KEY_UP      = 8'h1D;
  localparam logic [7:0] KEY_DOWN    = 8'h1B;
  localparam logic [7:0] KEY_RESTORE = 8'h2D;

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_REQ, S_WAIT_ACK, S_RESTORE
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        code_q, code_d;
  logic [1:0]        band_sel_q, band_sel_d;
  logic [1:0]        cfg_band_q, cfg_band_d;
  logic [GAIN_W-1:0] cfg_gain_q, cfg_gain_d;
  logic              cfg_req_q, cfg_req_d;
  logic              busy_q, busy_d;
  logic              key_drop_q, key_drop_d;
  logic              err_q, err_d;
  logic              restore_q, restore_d;
  logic [1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [GAIN_W-1:0] gain_q [MAX_BANDS];
  logic              gain_we;

  logic              band_key;
  logic [1:0]        band_idx;
  logic [GAIN_W-1:0] cur_gain;
  logic [GAIN_W-1:0] step_gain;

  // Band-key decode of the latched scan code
  always_comb begin
    band_key = 1'b0;
    band_idx = 2'd0;
    case (code_q)
      KEY_BAND0: begin band_key = 1'b1; band_idx = 2'd0; end
      KEY_BAND1: begin band_key = 1'b1; band_idx = 2'd1; end
      KEY_BAND2: begin band_key = 1'b1; band_idx = 2'd2; end
      KEY_BAND3: begin band_key = 1'b1; band_idx = 2'd3; end
      default:   ;
    endcase
  end

  // Saturating +/-1 step of the selected band's gain
  assign cur_gain  = gain_q[band_sel_q];
  assign step_gain = (code_q == KEY_UP)
                   ? ((cur_gain >= GAIN_W'(GAIN_MAX)) ? cur_gain : cur_gain + GAIN_W'(1))
                   : ((cur_gain == '0) ? cur_gain : cur_gain - GAIN_W'(1));

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    band_sel_d = band_sel_q;
    cfg_band_d = cfg_band_q;
    cfg_gain_d = cfg_gain_q;
    cfg_req_d  = cfg_req_q;
    restore_d  = restore_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    err_d      = 1'b0;
    gain_we    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.key_valid) begin
          code_d  = bus.key_code;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_IDLE;
        if (band_key) begin
          if (32'(band_idx) < NUM_BANDS) band_sel_d = band_idx;
        end else if (code_q == KEY_UP || code_q == KEY_DOWN) begin
          // A saturated step produces no write
          if (step_gain != cur_gain) begin
            cfg_band_d = band_sel_q;
            cfg_gain_d = step_gain;
            state_d    = S_REQ;
          end
        end else if (code_q == KEY_RESTORE) begin
          idx_d     = 2'd0;
          restore_d = 1'b1;
          state_d   = S_RESTORE;
        end
      end
      S_REQ: begin
        cfg_req_d = 1'b1;
        cnt_d     = '0;
        state_d   = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Ack is checked first so it wins over a coincident timeout
        if (bus.cfg_ack) begin
          cfg_req_d = 1'b0;
          gain_we   = 1'b1;
          state_d   = S_IDLE;
          if (restore_q) begin
            idx_d = idx_q + 2'd1;
            if (({1'b0, idx_q} + 3'd1) == 3'(NUM_BANDS)) restore_d = 1'b0;
            else                                         state_d   = S_RESTORE;
          end
        end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          cfg_req_d = 1'b0;
          err_d     = 1'b1;
          restore_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      S_RESTORE: begin
        cfg_band_d = idx_q;
        cfg_gain_d = GAIN_W'(GAIN_DEFAULT);
        state_d    = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase

    key_drop_d = bus.key_valid && (state_q != S_IDLE);
    busy_d     = (state_d != S_IDLE);
  end

  // Control and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      code_q     <= '0;
      band_sel_q <= '0;
      cfg_band_q <= '0;
      cfg_gain_q <= '0;
      cfg_req_q  <= 1'b0;
      busy_q     <= 1'b0;
      key_drop_q <= 1'b0;
      err_q      <= 1'b0;
      restore_q  <= 1'b0;
      idx_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      band_sel_q <= band_sel_d;
      cfg_band_q <= cfg_band_d;
      cfg_gain_q <= cfg_gain_d;
      cfg_req_q  <= cfg_req_d;
      busy_q     <= busy_d;
      key_drop_q <= key_drop_d;
      err_q      <= err_d;
      restore_q  <= restore_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
    end
  end

  // Per-band gain registers, committed only on an acknowledged write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(MAX_BANDS); i++) gain_q[i] <= GAIN_W'(GAIN_DEFAULT);
    end else if (gain_we) begin
      gain_q[cfg_band_q] <= cfg_gain_q;
    end
  end

  assign bus.band_sel    = band_sel_q;
  assign bus.cfg_req     = cfg_req_q;
  assign bus.cfg_band    = cfg_band_q;
  assign bus.cfg_gain    = cfg_gain_q;
  assign bus.busy        = busy_q;
  assign bus.key_drop    = key_drop_q;
  assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_eq_key_controller.sv
// Purpose: self-checking bench for eq_key_controller. A key-level model keeps
//          the per-band gains, the selected band and a queue of expected writes;
//          directed steps cover latency, saturation, restore, timeout, key drop
//          and reset, followed by randomized key/ack traffic.
module tb_eq_key_controller;
  localparam int NB      = 3;
  localparam int GMAX    = 15;
  localparam int GDEF    = 8;
  localparam int TIMEOUT = 255;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  eq_key_if #(.GAIN_W(4)) eq_bus ();

  eq_key_controller #(
    .NUM_BANDS(NB), .GAIN_W(4), .GAIN_MAX(GMAX), .GAIN_DEFAULT(GDEF), .ACK_TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(eq_bus)
  );

  always #5 clk = ~clk;

  // Model state
  int m_gain [4];
  int m_band;
  int exp_band_q [$];
  int exp_gain_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_gain[i] = GDEF;
    m_band = 0;
    exp_band_q.delete();
    exp_gain_q.delete();
  endfunction

  // Expected effect of one accepted key
  function automatic void model_key(input logic [7:0] c);
    int b;
    int nx;
    case (c)
      8'h16:   b = 0;
      8'h1E:   b = 1;
      8'h26:   b = 2;
      8'h25:   b = 3;
      default: b = -1;
    endcase
    if (b >= 0) begin
      if (b < NB) m_band = b;
    end else if (c == 8'h1D || c == 8'h1B) begin
      nx = m_gain[m_band] + ((c == 8'h1D) ? 1 : -1);
      if (nx > GMAX) nx = GMAX;
      if (nx < 0) nx = 0;
      if (nx != m_gain[m_band]) begin
        exp_band_q.push_back(m_band);
        exp_gain_q.push_back(nx);
      end
    end else if (c == 8'h2D) begin
      for (int i = 0; i < NB; i++) begin
        exp_band_q.push_back(i);
        exp_gain_q.push_back(GDEF);
      end
    end
  endfunction

  function automatic void commit_front();
    if (exp_band_q.size() > 0) begin
      m_gain[exp_band_q[0]] = exp_gain_q[0];
      void'(exp_band_q.pop_front());
      void'(exp_gain_q.pop_front());
    end
  endfunction

  function automatic void drop_front();
    if (exp_band_q.size() > 0) begin
      void'(exp_band_q.pop_front());
      void'(exp_gain_q.pop_front());
    end
  endfunction

  // Called at a negedge; leaves at the negedge after the sampling edge
  task automatic strobe(input logic [7:0] c);
    eq_bus.key_code  = c;
    eq_bus.key_valid = 1'b1;
    @(negedge clk);
    eq_bus.key_valid = 1'b0;
    eq_bus.key_code  = 8'($urandom);
  endtask

  task automatic wait_req();
    int cyc = 0;
    while (eq_bus.cfg_req !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("req_seen", eq_bus.cfg_req, 1);
  endtask

  // Acknowledge every write until the controller is idle, checking each one
  task automatic service(input int ack_dly);
    int cyc = 0;
    while (eq_bus.busy === 1'b1 && cyc < 2000) begin
      if (eq_bus.cfg_req === 1'b1) begin
        if (exp_band_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          check("wr_band", eq_bus.cfg_band, exp_band_q[0]);
          check("wr_gain", eq_bus.cfg_gain, exp_gain_q[0]);
        end
        for (int k = 0; k < ack_dly; k++) begin
          @(negedge clk);
          check("req_hold", eq_bus.cfg_req, 1);
          cyc++;
        end
        eq_bus.cfg_ack = 1'b1;
        @(negedge clk);
        eq_bus.cfg_ack = 1'b0;
        check("req_drop", eq_bus.cfg_req, 0);
        commit_front();
      end else begin
        @(negedge clk);
      end
      cyc++;
    end
    check("busy_end", eq_bus.busy, 0);
    check("pending_writes", exp_band_q.size(), 0);
    check("band_sel", eq_bus.band_sel, m_band);
  endtask

  task automatic press(input logic [7:0] c, input int ack_dly);
    model_key(c);
    strobe(c);
    service(ack_dly);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] keys [8];
    int high;
    logic [7:0] c;

    keys[0] = 8'h16; keys[1] = 8'h1E; keys[2] = 8'h26; keys[3] = 8'h25;
    keys[4] = 8'h1D; keys[5] = 8'h1B; keys[6] = 8'h2D; keys[7] = 8'h00;

    rst = 1'b1;
    eq_bus.key_code  = 8'h00;
    eq_bus.key_valid = 1'b0;
    eq_bus.cfg_ack   = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_band_sel", eq_bus.band_sel, 0);
    check("rst_cfg_req", eq_bus.cfg_req, 0);
    check("rst_cfg_band", eq_bus.cfg_band, 0);
    check("rst_cfg_gain", eq_bus.cfg_gain, 0);
    check("rst_busy", eq_bus.busy, 0);
    check("rst_key_drop", eq_bus.key_drop, 0);
    check("rst_err", eq_bus.err_timeout, 0);

    // Up key: cfg_req rises three clocks after the strobe
    model_key(8'h1D);
    strobe(8'h1D);
    check("lat_clk1", eq_bus.cfg_req, 0);
    @(negedge clk);
    check("lat_clk2", eq_bus.cfg_req, 0);
    @(negedge clk);
    check("lat_clk3", eq_bus.cfg_req, 1);
    check("lat_band", eq_bus.cfg_band, 0);
    check("lat_gain", eq_bus.cfg_gain, 9);
    service(2);

    // Band select and down, band key without write
    press(8'h1E, 0);
    press(8'h1B, 1);
    press(8'h26, 0);

    // Saturation at both ends on band 0
    press(8'h16, 0);
    for (int i = 0; i < 7; i++) press(8'h1D, 0);
    check("sat_top_model", m_gain[0], GMAX);
    for (int i = 0; i < 16; i++) press(8'h1B, 0);
    check("sat_bot_model", m_gain[0], 0);

    // Restore with immediate acks
    press(8'h2D, 0);

    // Withheld ack: timeout after 255 cycles of cfg_req, gain unchanged
    model_key(8'h1D);
    strobe(8'h1D);
    wait_req();
    high = 0;
    while (eq_bus.cfg_req === 1'b1 && high < 400) begin
      high++;
      @(negedge clk);
    end
    check("timeout_len", high, TIMEOUT);
    check("timeout_err", eq_bus.err_timeout, 1);
    check("timeout_busy", eq_bus.busy, 0);
    @(negedge clk);
    check("timeout_err_pulse", eq_bus.err_timeout, 0);
    drop_front();
    press(8'h1D, 0);

    // Ack in the last cycle before timeout: the write commits
    model_key(8'h1D);
    strobe(8'h1D);
    wait_req();
    repeat (TIMEOUT - 1) @(negedge clk);
    check("late_req", eq_bus.cfg_req, 1);
    eq_bus.cfg_ack = 1'b1;
    @(negedge clk);
    eq_bus.cfg_ack = 1'b0;
    check("late_err", eq_bus.err_timeout, 0);
    check("late_req_drop", eq_bus.cfg_req, 0);
    check("late_busy", eq_bus.busy, 0);
    commit_front();
    press(8'h1B, 0);

    // Key during WAIT_ACK is dropped
    model_key(8'h1D);
    strobe(8'h1D);
    wait_req();
    strobe(8'h1E);
    check("drop_pulse", eq_bus.key_drop, 1);
    check("drop_req", eq_bus.cfg_req, 1);
    eq_bus.cfg_ack = 1'b1;
    @(negedge clk);
    eq_bus.cfg_ack = 1'b0;
    check("drop_pulse_end", eq_bus.key_drop, 0);
    check("drop_req_drop", eq_bus.cfg_req, 0);
    commit_front();
    @(negedge clk);
    check("drop_busy", eq_bus.busy, 0);
    check("drop_band_sel", eq_bus.band_sel, m_band);

    // Reset during WAIT_ACK
    model_key(8'h1D);
    strobe(8'h1D);
    wait_req();
    rst = 1'b1;
    #1;
    check("rst_async_req", eq_bus.cfg_req, 0);
    check("rst_async_busy", eq_bus.busy, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    press(8'h1D, 0);
    press(8'h1E, 0);
    press(8'h1D, 1);
    press(8'h26, 0);
    press(8'h1D, 0);

    // Randomized key and ack traffic, with occasional stray acks while idle
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        eq_bus.cfg_ack = 1'b1;
        @(negedge clk);
        eq_bus.cfg_ack = 1'b0;
        check("stray_ack_req", eq_bus.cfg_req, 0);
      end
      c = keys[$urandom_range(0, 7)];
      if (c == 8'h00) c = 8'($urandom);
      press(c, $urandom_range(0, 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
